// File: rtl/adder.sv
// adder: parallel-prefix (Kogge-Stone) dual-sum adder producing {p, g, a+b, a+b+1} plus a reset-tracking valid flag
module adder #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 guard,
    output logic [2*WIDTH+1:0]   res,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b
);
    localparam int LV = (WIDTH > 1) ? $clog2(WIDTH) : 0;
    logic [WIDTH-1:0] pi_bits;
    logic [WIDTH-1:0] gk;
    logic [WIDTH-1:0] pk;
    logic [WIDTH-1:0] gn;
    logic [WIDTH-1:0] pn;
    logic [WIDTH-1:0] c0;
    logic [WIDTH-1:0] c1;
    logic             guard_q;
    // Kogge-Stone prefix tree: each level combines with the span 2^l bits below
    always_comb begin
        gk = a & b;
        pk = a ^ b;
        gn = gk;
        pn = pk;
        for (int l = 0; l < LV; l++) begin
            gn = gk;
            pn = pk;
            for (int i = (1 << l); i < WIDTH; i++) begin
                gn[i] = gk[i] | (pk[i] & gk[i - (1 << l)]);
                pn[i] = pk[i] & pk[i - (1 << l)];
            end
            gk = gn;
            pk = pn;
        end
    end
    assign pi_bits = a ^ b;
    assign c0      = gk << 1;
    assign c1      = ((gk | pk) << 1) | WIDTH'(1);
    assign res     = {pk[WIDTH-1], gk[WIDTH-1], pi_bits ^ c0, pi_bits ^ c1};
    // valid flag: low while reset is sampled, high from the first released edge onward
    always_ff @(posedge clk) begin
        guard_q <= rst_n ? 1'b1 : 1'b0;
    end
    assign guard = guard_q;
endmodule

// File: tb/tb_adder.sv
// tb_adder: directed and randomized checks of adder at WIDTH 4, 5 and 8 against an arithmetic reference model
module tb_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [4:0]  a5 = '0, b5 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [9:0]  res4;
    logic [11:0] res5;
    logic [17:0] res8;
    logic        guard4, guard5, guard8;
    int          passed = 0;
    int          total = 0;

    always #5 clk = ~clk;

    adder #(.WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .guard(guard4), .res(res4), .a(a4), .b(b4));
    adder #(.WIDTH(5)) dut5 (.clk(clk), .rst_n(rst_n), .guard(guard5), .res(res5), .a(a5), .b(b5));
    adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .guard(guard8), .res(res8), .a(a8), .b(b8));

    // expected {p, g, s, t} from plain integer arithmetic
    function automatic logic [31:0] ref_res(int w, int x, int y);
        int m = 1 << w;
        int s = (x + y) % m;
        int t = (x + y + 1) % m;
        int g = ((x + y) >= m) ? 1 : 0;
        int p = ((x ^ y) == (m - 1)) ? 1 : 0;
        return 32'((((p << 1) | g) << (2 * w)) | (s << w) | t);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic set4(input int x, input int y);
        @(negedge clk);
        a4 = 4'(x);
        b4 = 4'(y);
        #1;
    endtask

    initial begin
        int bs[5] = '{1, 2, 4, 8, 0};
        int x, y;
        // reset held two cycles
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("guard_in_reset", {31'b0, guard4}, 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("guard_first_edge", {31'b0, guard4}, 32'd1);
        chk("guard5_first_edge", {31'b0, guard5}, 32'd1);
        chk("guard8_first_edge", {31'b0, guard8}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("guard_stays", {31'b0, guard4}, 32'd1);
        // directed vectors
        set4(0, 1);
        chk("v_0_1", {22'b0, res4}, {22'b0, 10'b00_0001_0010});
        set4(5, 10);
        chk("v_5_10", {22'b0, res4}, {22'b0, 10'b10_1111_0000});
        set4(15, 1);
        chk("v_15_1", {22'b0, res4}, {22'b0, 10'b01_0000_0001});
        set4(15, 15);
        chk("v_15_15", {22'b0, res4}, {22'b0, 10'b01_1110_1111});
        set4(0, 0);
        chk("v_0_0", {22'b0, res4}, {22'b0, 10'b00_0000_0001});
        // sweep a for each listed b
        foreach (bs[k]) begin
            for (int i = 0; i < 16; i++) begin
                set4(i, bs[k]);
                chk($sformatf("sweep_a%0d_b%0d", i, bs[k]), {22'b0, res4}, ref_res(4, i, bs[k]));
            end
        end
        // mid-operation reset: guard drops at the edge, result keeps tracking inputs
        @(negedge clk);
        rst_n = 1'b0;
        a4 = 4'd9;
        b4 = 4'd7;
        @(posedge clk);
        #1;
        chk("guard_mid_reset", {31'b0, guard4}, 32'd0);
        chk("res_during_reset", {22'b0, res4}, ref_res(4, 9, 7));
        set4(6, 9);
        chk("res_during_reset2", {22'b0, res4}, ref_res(4, 6, 9));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("guard_after_rerelease", {31'b0, guard4}, 32'd1);
        // random operands at all three widths
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            x = int'($urandom_range(0, 255));
            y = int'($urandom_range(0, 255));
            a4 = 4'(x);
            b4 = 4'(y);
            a5 = 5'(x);
            b5 = 5'(y);
            a8 = 8'(x);
            b8 = 8'(y);
            #1;
            chk("rand_w4", {22'b0, res4}, ref_res(4, x % 16, y % 16));
            chk("rand_w5", {20'b0, res5}, ref_res(5, x % 32, y % 32));
            chk("rand_w8", {14'b0, res8}, ref_res(8, x, y));
        end
        // width extremes for the wider builds
        @(negedge clk);
        a5 = 5'h1f;
        b5 = 5'h1f;
        a8 = 8'hff;
        b8 = 8'h01;
        #1;
        chk("w5_all_ones", {20'b0, res5}, ref_res(5, 31, 31));
        chk("w8_wrap", {14'b0, res8}, ref_res(8, 255, 1));
        @(negedge clk);
        a8 = 8'h55;
        b8 = 8'haa;
        #1;
        chk("w8_full_prop", {14'b0, res8}, ref_res(8, 85, 170));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/adder.md
ADDER -- requirements
Module: adder

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits (SHALL be >= 1; power of two not required).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 guard  output  1  result-valid flag; high when res is valid for consumption.
REQ-005 res  output  2*WIDTH+2  packed result {p, g, s, t}, MSB first.
REQ-006 a  input  WIDTH  first unsigned operand.
REQ-007 b  input  WIDTH  second unsigned operand.
REQ-008 Port order SHALL be (clk, rst_n, guard, res, a, b).

Function
REQ-009 Field map (WIDTH=4): res[9]=p, res[8]=g, res[7:4]=s, res[3:0]=t; generally p=res[2W+1], g=res[2W], s=res[2W-1:W], t=res[W-1:0].
REQ-010 s SHALL equal (a + b) mod 2^WIDTH (sum, carry-in 0).
REQ-011 t SHALL equal (a + b + 1) mod 2^WIDTH (incremented sum, carry-in 1).
REQ-012 p (group propagate) SHALL equal AND over all bits of (a XOR b).
REQ-013 g (group generate) SHALL equal the carry-out of a + b with carry-in 0.
REQ-014 Carry-out of a+b+1 equals g OR p; SHALL not be output, but s/t/p/g SHALL be consistent with it.
REQ-015 res SHALL be purely combinational from a and b: no pipeline, zero-cycle latency, settles within the same clock cycle operands change.
REQ-016 res SHALL not depend on rst_n or guard; it is valid whenever a and b are stable.
REQ-017 Carry computation SHALL use per-bit generate/propagate (gi=ai&bi, pi=ai^bi) combined by a parallel-prefix tree (Kogge-Stone or Brent-Kung), depth ceil(log2 WIDTH) combine levels; no ripple chain.
REQ-018 Prefix combine operator: (G,P)o(G',P') = (G | P&G', P&P').
REQ-019 Sum bits: s[i]=pi XOR C0[i], t[i]=pi XOR C1[i], where C0[i]/C1[i] are carries into bit i for carry-in 0/1; C0[i]=Gpre[i-1], C1[i]=Gpre[i-1]|Ppre[i-1], C0[0]=0, C1[0]=1.
REQ-020 p and g SHALL be the full-width prefix (P,G) of bits WIDTH-1..0.
REQ-021 Wrap-around: all-ones operands and carry overflow SHALL wrap modulo 2^WIDTH with no saturation; no X on any output for any 0/1 input.
REQ-022 guard SHALL be a single flip-flop: cleared on reset, set to 1 on the first rising edge with rst_n=1, remaining 1 until next reset.

Reset
REQ-023 On rising clk with rst_n=0, guard SHALL become 0; reset SHALL not be sampled asynchronously.
REQ-024 Reset asserted mid-operation SHALL drop guard at that edge; res continues to track a, b combinationally.
REQ-025 guard is undefined before the first clock edge; benches SHALL apply reset for at least one cycle.

Verification
REQ-026 rst_n=0 for 2 cycles, then 1 -> guard=0 during reset, guard=1 after first edge with rst_n=1 and stays 1.
REQ-027 a=0000, b=0001 -> s=0001, t=0010, p=0, g=0, res=00_0001_0010.
REQ-028 a=0101, b=1010 -> s=1111, t=0000, p=1, g=0 (full propagate, t wraps).
REQ-029 a=1111, b=0001 -> s=0000, t=0001, p=0, g=1; a=1111, b=1111 -> s=1110, t=1111, p=0, g=1.
REQ-030 Exhaustive sweep, a=0..15 for each b in {1,2,4,8,0} -> every res matches REQ-010..013 against a reference model, zero mismatches.
REQ-031 WIDTH=5 and WIDTH=8 builds with random operands -> res matches reference model; res width 2*WIDTH+2.
